m_mux_arbiter: RTL and testbench
================================

// Module: m_mux_arbiter
// PURPOSE
//  Gathering end of the m_demux fan-out path: collects up to 4 request lines into one output stream.
//  Each channel offers a valid/data word. A round-robin arbiter grants one channel per cycle.
//  The granted word and its 2-bit channel code are registered on a valid/ready output.
//  The code (out_sel) matches the select encoding that m_demux uses to route a response back.
// PARAMETERS
//  WORD   8  data width per channel
//  DEMUX  2  select/code width; channel count is fixed at 4 (2**DEMUX)
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous, active-low reset
//  in_valid   in   4          per-channel request; bit k = channel k
//  in_data    in   4*WORD     channel k data at [k*WORD +: WORD]
//  in_ready   out  4          one-hot accept strobe; combinational
//  out_valid  out  1          output register holds a word
//  out_data   out  WORD       granted data word
//  out_sel    out  DEMUX      code of the granted channel (00..11)
//  out_ready  in   1          downstream accept
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0.
//   - in_ready=4'b0000 while rst_n=0.
//   - A word held at reset is dropped, not replayed.
//  State: EMPTY (out_valid=0) / FULL (out_valid=1).
//  load = |in_valid && (!out_valid || out_ready).
//  Grant g: the first k with in_valid[k]=1, searching ptr, ptr+1, ... mod 4.
//  in_ready = load ? onehot(g) : 4'b0000.
//   - At most one bit is set. A transfer on channel k is in_valid[k] && in_ready[k].
//  On a clock edge with load:
//   - out_data <= in_data[g], out_sel <= g, out_valid <= 1.
//   - ptr <= (g+1) mod 4; wraps 3 -> 0.
//  On a clock edge with out_valid && out_ready && !load: out_valid <= 0; out_data/out_sel keep their values.
//  Drain and load in the same cycle: the output is replaced with no bubble; throughput is 1 word/cycle.
//  FULL && !out_ready:
//   - out_data/out_sel are held stable, in_ready=0000, ptr unchanged.
//  Latency: a word accepted at edge N is visible on out_* after edge N; a single register stage.
//  ptr advances only on a grant. Idle cycles do not move it.
//  Channels with in_valid=0 are skipped without a cycle penalty.
//  Fairness: a continuously valid channel waits at most 3 grants.
//  in_valid/in_data may change freely while not granted. No combinational path from in_* to out_*.
//  in_ready depends combinationally on in_valid, out_valid, out_ready and ptr.
// TESTING
//  1 Reset: rst_n=0, all in_valid=1 -> out_valid=0, out_data=0, out_sel=00, in_ready=0000.
//  2 Single: in_valid=0100, ch2 data=8'hA5, out_ready=1 -> in_ready=0100 that cycle.
//    Next cycle: out_valid=1, out_data=A5, out_sel=10.
//  3 Round robin: in_valid=1111 held, out_ready=1, ptr=0, data k=8'h10+k.
//    -> out_sel 00,01,10,11,00 on consecutive cycles; data 10,11,12,13,10.
//  4 Backpressure: FULL with ch1=8'h3C, out_ready=0 for 5 cycles.
//    -> out_data=3C, out_sel=01 stable; in_ready=0000.
//    Then out_ready=1 -> same cycle grant to ch2 if valid (ptr=2).
//  5 Wrap/skip: ptr=3, in_valid=1001 -> grant ch3 (sel 11), then ch0 (sel 00); ch1/ch2 never granted.
//  6 Reset mid-operation: out_valid=1, drop rst_n between edges.
//    -> out_valid=0 immediately, async. After release with in_valid=0: stays EMPTY, ptr=0.

Source files
------------

// File: rtl/m_mux_arbiter.sv
// m_mux_arbiter: gathers up to 2**DEMUX valid/data request channels into one
// registered valid/ready output stream. A round-robin pointer picks the grant.
// out_sel carries the granted channel code so m_demux can route the response
// back to the same channel.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_EMPTY | output register holds no word (out_valid=0)
// S_FULL  | output register holds a word waiting for out_ready

module m_mux_arbiter #(
  parameter int WORD  = 8,
  parameter int DEMUX = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [(2**DEMUX)-1:0]         in_valid,
  input  logic [(2**DEMUX)*WORD-1:0]    in_data,
  output logic [(2**DEMUX)-1:0]         in_ready,
  output logic                          out_valid,
  output logic [WORD-1:0]               out_data,
  output logic [DEMUX-1:0]              out_sel,
  input  logic                          out_ready
);

  localparam int NCH = 2**DEMUX;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [DEMUX-1:0] ptr_q;
  logic [DEMUX-1:0] gnt;
  logic [DEMUX-1:0] idx;
  logic             gnt_found;
  logic             load;

  assign out_valid = (state_q == S_FULL);

  // Round-robin search starting at ptr_q; the index wraps naturally in DEMUX bits.
  always_comb begin
    gnt_found = 1'b0;
    gnt       = ptr_q;
    idx       = ptr_q;
    for (int i = 0; i < NCH; i++) begin
      idx = ptr_q + DEMUX'(i);
      if (!gnt_found && in_valid[idx]) begin
        gnt_found = 1'b1;
        gnt       = idx;
      end
    end
  end

  // A word can enter when some channel requests and the output slot is free or draining.
  assign load = gnt_found && (!out_valid || out_ready);

  // One-hot accept strobe; forced low while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (rst_n && load) begin
      in_ready[gnt] = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load always fills; a drain without a load empties.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        if (load) state_d = S_FULL;
      end
      S_FULL: begin
        if (load)           state_d = S_FULL;
        else if (out_ready) state_d = S_EMPTY;
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Output word, channel code and round-robin pointer update only on a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sel  <= '0;
      ptr_q    <= '0;
    end else if (load) begin
      out_data <= in_data[int'(gnt)*WORD +: WORD];
      out_sel  <= gnt;
      ptr_q    <= gnt + DEMUX'(1);
    end
  end

endmodule

// File: tb/tb_m_mux_arbiter.sv
// tb_m_mux_arbiter: directed, table-driven bench for m_mux_arbiter.
module tb_m_mux_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_ready;

  int n_checks = 0;
  int n_fail   = 0;

  m_mux_arbiter #(.WORD(8), .DEMUX(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  iv;
    logic [31:0] id;
    logic        ordy;
    logic [3:0]  e_ird;
    logic        e_ov;
    logic [7:0]  e_od;
    logic [1:0]  e_os;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ov, input logic [7:0] od, input logic [1:0] os);
    chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, ov});
    chk({tag, ".out_data"},  {24'd0, out_data},  {24'd0, od});
    chk({tag, ".out_sel"},   {30'd0, out_sel},   {30'd0, os});
  endtask

  initial begin
    // single grant on ch2, then idle drain
    vecs[0]  = '{4'b0100, 32'h00A5_0000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    // bring ptr back to 0 via ch3
    vecs[2]  = '{4'b1000, 32'h1300_0000, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    // round robin with all channels valid
    vecs[3]  = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[4]  = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vecs[5]  = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vecs[6]  = '{4'b1111, 32'h1312_1110, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vecs[7]  = '{4'b1111, 32'h1312_1110, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    // load ch1=3C, then backpressure for 5 cycles, then release -> ch2
    vecs[8]  = '{4'b0010, 32'h0000_3C00, 1'b1, 4'b0010, 1'b1, 8'h3C, 2'd1};
    vecs[9]  = '{4'b1111, 32'h1312_3C10, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    vecs[10] = '{4'b1111, 32'h1312_3C10, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    vecs[11] = '{4'b1111, 32'h1312_3C10, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    vecs[12] = '{4'b1111, 32'h1312_3C10, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    vecs[13] = '{4'b1111, 32'h1312_3C10, 1'b0, 4'b0000, 1'b1, 8'h3C, 2'd1};
    vecs[14] = '{4'b1111, 32'h1312_3C10, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    // wrap/skip from ptr=3 with only ch0 and ch3 valid
    vecs[15] = '{4'b1001, 32'hB300_00A0, 1'b1, 4'b1000, 1'b1, 8'hB3, 2'd3};
    vecs[16] = '{4'b1001, 32'hB300_00A0, 1'b1, 4'b0001, 1'b1, 8'hA0, 2'd0};
    vecs[17] = '{4'b1001, 32'hB300_00A0, 1'b1, 4'b1000, 1'b1, 8'hB3, 2'd3};
    // drain without load keeps data/sel
    vecs[18] = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hB3, 2'd3};
    // load into empty slot with out_ready low, then hold
    vecs[19] = '{4'b1111, 32'h1312_1110, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0};
    vecs[20] = '{4'b1111, 32'h1312_1110, 1'b0, 4'b0000, 1'b1, 8'h10, 2'd0};

    // Reset with all channels requesting
    rst_n     = 1'b0;
    in_valid  = 4'b1111;
    in_data   = 32'h1312_1110;
    out_ready = 1'b1;
    #2;
    chk("rst.in_ready", {28'd0, in_ready}, 32'h0);
    chk_out("rst", 1'b0, 8'h00, 2'd0);
    @(posedge clk); #1;
    chk("rst_edge.in_ready", {28'd0, in_ready}, 32'h0);
    chk_out("rst_edge", 1'b0, 8'h00, 2'd0);

    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 21; v++) begin
      in_valid  = vecs[v].iv;
      in_data   = vecs[v].id;
      out_ready = vecs[v].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", v), {28'd0, in_ready}, {28'd0, vecs[v].e_ird});
      @(posedge clk); #1;
      chk_out($sformatf("v%0d", v), vecs[v].e_ov, vecs[v].e_od, vecs[v].e_os);
    end

    // Reset mid-operation: FULL with ch0/10, ptr=1; async drop between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 8'h00, 2'd0);
    chk("midrst.in_ready", {28'd0, in_ready}, 32'h0);
    in_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_out("post_rst_idle", 1'b0, 8'h00, 2'd0);
    @(posedge clk); #1;
    chk_out("post_rst_idle2", 1'b0, 8'h00, 2'd0);

    // ptr must be 0 again: all-valid grants ch0 first
    in_valid  = 4'b1111;
    in_data   = 32'h1312_1110;
    out_ready = 1'b1;
    #1;
    chk("post_rst.in_ready", {28'd0, in_ready}, 32'h1);
    @(posedge clk); #1;
    chk_out("post_rst_grant", 1'b1, 8'h10, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
